// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and decode-side handshake bundle for fetch_unit
//   master : the fetch unit (drives imem_req/imem_addr and the IR outputs)
//   slave  : the surroundings (memory ack/rdata, redirect source, decode ready)
//   imem_req/imem_addr/imem_ack/imem_rdata : word fetch req/ack handshake
//   redirect_valid/redirect_pc             : taken-jump restart
//   ir_valid/ir_ready/ir/ir_pc/opcode      : IR presented to decode
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [INST_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic [2:0]        opcode;
    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc, opcode,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, ir_ready
    );
    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc, opcode,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, ir_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: S1 instruction fetch stage -- PC, imem req/ack, single-entry IR to decode
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : fetch_unit_if.master (imem handshake, redirect, IR valid/ready + opcode)
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_unit_if.master  bus
);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    // Redirect wins over ack/ready; an ack only counts while requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (bus.redirect_valid) begin
            state    <= FETCH;
            pc       <= bus.redirect_pc;
            ir_valid <= 1'b0;
        end else if (state == FETCH) begin
            if (bus.imem_ack) begin
                state    <= HOLD;
                ir       <= bus.imem_rdata;
                ir_pc    <= pc;
                pc       <= pc + 1'b1;
                ir_valid <= 1'b1;
            end
        end else if (bus.ir_ready) begin
            state    <= FETCH;
            ir_valid <= 1'b0;
        end
    end
    // Request is gated by rst so an in-flight fetch is dropped immediately.
    assign bus.imem_req  = (state == FETCH) && !rst;
    assign bus.imem_addr = pc;
    assign bus.ir_valid  = ir_valid;
    assign bus.ir        = ir;
    assign bus.ir_pc     = ir_pc;
    assign bus.opcode    = ir[INST_W-1 -: 3];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with directed and random stimulus
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fetch_unit_if #(.ADDR_W(16), .INST_W(16)) bus ();
    fetch_unit_if #(.ADDR_W(16), .INST_W(16)) wbus ();
    fetch_unit #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );
    fetch_unit #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus.master)
    );
    assign wbus.imem_ack       = 1'b1;
    assign wbus.imem_rdata     = 16'h1234;
    assign wbus.redirect_valid = 1'b0;
    assign wbus.redirect_pc    = 16'h0000;
    assign wbus.ir_ready       = 1'b1;
    int checks = 0;
    int errors = 0;
    logic        mon_en = 1'b0;
    logic        hold   = 1'b0;
    logic [15:0] m_pc   = 16'h0000;
    logic [31:0] exp_q[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Apply one cycle of inputs, then advance the transaction model across the edge.
    task automatic step(input logic a, input logic [15:0] d, input logic rv,
                        input logic [15:0] rp, input logic rd, input logic r);
        bus.imem_ack       = a;
        bus.imem_rdata     = d;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.ir_ready       = rd;
        rst                = r;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            hold = 1'b0;
            m_pc = 16'h0000;
        end else if (rv) begin
            hold = 1'b0;
            m_pc = rp;
        end else if (!hold && a) begin
            exp_q.push_back({d, m_pc});
            m_pc = m_pc + 16'h1;
            hold = 1'b1;
        end else if (hold && rd) begin
            hold = 1'b0;
        end
        #2;
    endtask
    // Monitor: compare the presented IR with the scoreboard head; retire on consume/discard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("imem_req", {31'b0, bus.imem_req}, {31'b0, !hold && !rst});
            if (bus.imem_req) chk("imem_addr", {16'b0, bus.imem_addr}, {16'b0, m_pc});
            chk("ir_valid", {31'b0, bus.ir_valid}, {31'b0, hold});
            if (bus.ir_valid) begin
                if (exp_q.size() == 0) begin
                    chk("ir_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("ir", {16'b0, bus.ir}, {16'b0, exp_q[0][31:16]});
                    chk("ir_pc", {16'b0, bus.ir_pc}, {16'b0, exp_q[0][15:0]});
                    chk("opcode", {29'b0, bus.opcode}, {29'b0, exp_q[0][31:29]});
                    if ((bus.ir_ready || bus.redirect_valid) && !rst) void'(exp_q.pop_front());
                end
            end
        end
    end
    // Wrap instance: RESET_PC all-ones fetches from FFFF, then wraps to 0000.
    initial begin
        @(negedge rst);
        @(negedge clk);
        chk("wrap_req0", {31'b0, wbus.imem_req}, 32'd1);
        chk("wrap_addr0", {16'b0, wbus.imem_addr}, 32'h0000FFFF);
        @(negedge clk);
        chk("wrap_ir_valid", {31'b0, wbus.ir_valid}, 32'd1);
        chk("wrap_ir_pc", {16'b0, wbus.ir_pc}, 32'h0000FFFF);
        chk("wrap_ir", {16'b0, wbus.ir}, 32'h00001234);
        @(negedge clk);
        chk("wrap_req1", {31'b0, wbus.imem_req}, 32'd1);
        chk("wrap_addr1", {16'b0, wbus.imem_addr}, 32'h00000000);
    end
    initial begin
        step(0, 16'h0, 0, 16'h0, 0, 1);
        chk("rst_ir", {16'b0, bus.ir}, 32'd0);
        chk("rst_ir_pc", {16'b0, bus.ir_pc}, 32'd0);
        chk("rst_opcode", {29'b0, bus.opcode}, 32'd0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        mon_en = 1'b1;
        step(0, 16'h0, 0, 16'h0, 0, 1);
        // ack every fetch, decode always ready
        for (int i = 0; i < 6; i++) step(1, 16'h1000 + 16'(i), 0, 16'h0, 1, 0);
        // ack delayed three cycles
        for (int i = 0; i < 3; i++) step(0, 16'hDEAD, 0, 16'h0, 1, 0);
        step(1, 16'h2222, 0, 16'h0, 0, 0);
        // decode stalls for five cycles, then releases
        for (int i = 0; i < 5; i++) step(1, 16'hBEEF, 0, 16'h0, 0, 0);
        step(0, 16'h0, 0, 16'h0, 1, 0);
        chk("after_ready_addr", {16'b0, bus.imem_addr}, {16'b0, m_pc});
        // redirect collides with ack: IR must not load A5A5
        step(1, 16'hA5A5, 1, 16'h0040, 0, 0);
        chk("redir_addr", {16'b0, bus.imem_addr}, 32'h00000040);
        chk("redir_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("redir_ir", {16'b0, bus.ir}, 32'h00002222);
        // reset while holding with decode ready
        step(1, 16'h7777, 0, 16'h0, 0, 0);
        step(0, 16'h0, 0, 16'h0, 1, 1);
        chk("rst_hold_valid", {31'b0, bus.ir_valid}, 32'd0);
        step(1, 16'h0, 0, 16'h0, 0, 1);
        chk("rst_hold_req", {31'b0, bus.imem_req}, 32'd0);
        step(0, 16'h0, 0, 16'h0, 0, 0);
        chk("rst_pc", {16'b0, bus.imem_addr}, 32'd0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        a, rv, rd, r;
            logic [15:0] rp;
            a  = $urandom_range(0, 9) < 4;
            rd = $urandom_range(0, 9) < 5;
            rv = $urandom_range(0, 9) == 0;
            r  = $urandom_range(0, 199) == 0;
            rp = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            step(a, 16'($urandom), rv, rp, rd, r);
        end
        for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 16'h0, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
